// File: rtl/host_bus_port_if.sv
// Host bus port interface: request stream, device strobes, response stream and
// status flags. The bidirectional data bus stays a plain inout port on the module.
// slave  = the host_bus_port itself
// master = whatever drives upstream requests and models the device side
interface host_bus_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_last_i;
  logic       tx_ready_o;
  logic       oe_o;
  logic       host_stb_o;
  logic       dev_stb_i;
  logic       dev_eop_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_last_o;
  logic       busy_o;
  logic       bus_err_o;
  logic       timeout_o;

  modport slave (
    input  tx_data_i, tx_valid_i, tx_last_i, dev_stb_i, dev_eop_i,
    output tx_ready_o, oe_o, host_stb_o, rx_data_o, rx_valid_o, rx_last_o,
           busy_o, bus_err_o, timeout_o
  );

  modport master (
    output tx_data_i, tx_valid_i, tx_last_i, dev_stb_i, dev_eop_i,
    input  tx_ready_o, oe_o, host_stb_o, rx_data_o, rx_valid_o, rx_last_o,
           busy_o, bus_err_o, timeout_o
  );
endinterface

// File: rtl/host_bus_port.sv
// host_bus_port: host end of a shared 8-bit bidirectional bus.
// Sends a request packet, turns the bus around, captures the device response
// and presents it upstream as a valid/last stream.
// Optional feature macro: HOST_BUS_PORT_TIMEOUT_EN (RX idle timeout abort).
module host_bus_port #(
  parameter int TURN_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  inout  wire  [7:0] data_io,
  host_bus_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN_RX,
    S_RX,
    S_TURN_TX
  } state_t;

  localparam int TW = (TURN_CYCLES < 1) ? 1 : $clog2(TURN_CYCLES + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("host_bus_port: TURN_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("host_bus_port: TIMEOUT_CYCLES must be >= 2");
  end

  state_t          r_state;
  logic            r_oe;
  logic            r_host_stb;
  logic            r_tx_ready;
  logic [7:0]      r_bus_q;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_rx_last;
  logic            r_busy;
  logic            r_bus_err;
  logic [TW-1:0]   r_turn_cnt;
  logic            w_tx_accept;

`ifdef HOST_BUS_PORT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] TIMEOUT_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic            r_timeout;
  logic [IW-1:0]   r_idle_cnt;
`endif

  // r_tx_ready is only ever high in IDLE/TX, so it alone gates acceptance
  assign w_tx_accept = bus.tx_valid_i & r_tx_ready;

  // Host drives the shared bus only while it owns it
  assign data_io = r_oe ? r_bus_q : 8'bz;

  assign bus.oe_o       = r_oe;
  assign bus.host_stb_o = r_host_stb;
  assign bus.tx_ready_o = r_tx_ready;
  assign bus.rx_data_o  = r_rx_data;
  assign bus.rx_valid_o = r_rx_valid;
  assign bus.rx_last_o  = r_rx_last;
  assign bus.busy_o     = r_busy;
  assign bus.bus_err_o  = r_bus_err;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
  assign bus.timeout_o  = r_timeout;
`else
  assign bus.timeout_o  = 1'b0;
`endif

  // Transfer FSM: sequences TX, turnarounds and RX with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_oe       <= 1'b0;
      r_host_stb <= 1'b0;
      r_tx_ready <= 1'b0;
      r_bus_q    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_bus_err  <= 1'b0;
      r_turn_cnt <= '0;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
      r_timeout  <= 1'b0;
      r_idle_cnt <= '0;
`endif
    end else begin
      // Pulse outputs default low; set below only when an event occurs
      r_host_stb <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
      // A device strobe while we own the bus is a contention error, no state change
      r_bus_err  <= bus.dev_stb_i & r_oe;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif

      case (r_state)
        S_IDLE: begin
          r_oe   <= 1'b0;
          r_busy <= 1'b0;
          if (w_tx_accept) begin
            r_bus_q    <= bus.tx_data_i;
            r_host_stb <= 1'b1;
            r_oe       <= 1'b1;
            r_busy     <= 1'b1;
            r_tx_ready <= ~bus.tx_last_i;
            r_state    <= S_TX;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end

        S_TX: begin
          if (!r_tx_ready) begin
            // Last byte was on the bus this cycle; release and turn around
            r_oe       <= 1'b0;
            r_turn_cnt <= '0;
            r_state    <= S_TURN_RX;
          end else if (w_tx_accept) begin
            r_bus_q    <= bus.tx_data_i;
            r_host_stb <= 1'b1;
            r_tx_ready <= ~bus.tx_last_i;
          end
        end

        S_TURN_RX: begin
          // Bus idle; device strobes are deliberately ignored here
          if (r_turn_cnt >= TURN_LAST) begin
            r_turn_cnt <= '0;
            r_state    <= S_RX;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
          end else begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
          end
        end

        S_RX: begin
          if (bus.dev_stb_i) begin
            // A strobe always wins, even in the cycle the idle counter expires
            r_rx_data  <= data_io;
            r_rx_valid <= 1'b1;
            r_rx_last  <= bus.dev_eop_i;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
            if (bus.dev_eop_i) begin
              r_turn_cnt <= '0;
              r_state    <= S_TURN_TX;
            end
          end
`ifdef HOST_BUS_PORT_TIMEOUT_EN
          else if (r_idle_cnt >= TIMEOUT_LAST) begin
            // Abort: close the upstream packet with a zero terminator byte
            r_timeout  <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b1;
            r_rx_last  <= 1'b1;
            r_idle_cnt <= '0;
            r_turn_cnt <= '0;
            r_state    <= S_TURN_TX;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
`endif
        end

        S_TURN_TX: begin
          if (r_turn_cnt >= TURN_LAST) begin
            r_turn_cnt <= '0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_turn_cnt <= r_turn_cnt + 1'b1;
          end
        end

        default: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_bus_port.sv
// Directed testbench for host_bus_port (TURN_CYCLES=1, TIMEOUT_CYCLES=64).
// Inputs change on the falling edge, outputs are checked on the falling edge
// after the rising edge under test.
`timescale 1ns/1ps
module tb_host_bus_port;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  wire  [7:0] data_io;
  logic       dev_drive = 1'b0;
  logic [7:0] dev_data  = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  host_bus_if bus ();

  assign data_io = dev_drive ? dev_data : 8'bz;

  host_bus_port #(
    .TURN_CYCLES    (1),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_io (data_io),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] wb;
    logic       saw_valid;
    logic       saw_timeout;

    bus.tx_data_i  = 8'h00;
    bus.tx_valid_i = 1'b0;
    bus.tx_last_i  = 1'b0;
    bus.dev_stb_i  = 1'b0;
    bus.dev_eop_i  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_oe",       {7'd0, bus.oe_o},       8'h00);
    chk("rst_busy",     {7'd0, bus.busy_o},     8'h00);
    chk("rst_ready",    {7'd0, bus.tx_ready_o}, 8'h00);
    chk("rst_hstb",     {7'd0, bus.host_stb_o}, 8'h00);
    chk("rst_rxv",      {7'd0, bus.rx_valid_o}, 8'h00);
    chk("rst_rxdata",   bus.rx_data_o,          8'h00);
    chk("rst_buserr",   {7'd0, bus.bus_err_o},  8'h00);
    chk("rst_timeout",  {7'd0, bus.timeout_o},  8'h00);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", {7'd0, bus.tx_ready_o}, 8'h01);

    // Two-byte request back-to-back, then turnaround
    bus.tx_valid_i = 1'b1; bus.tx_data_i = 8'hF0; bus.tx_last_i = 1'b0;
    tick();
    chk("tx0_oe",    {7'd0, bus.oe_o},       8'h01);
    chk("tx0_hstb",  {7'd0, bus.host_stb_o}, 8'h01);
    chk("tx0_data",  data_io,                8'hF0);
    chk("tx0_busy",  {7'd0, bus.busy_o},     8'h01);
    chk("tx0_ready", {7'd0, bus.tx_ready_o}, 8'h01);
    bus.tx_data_i = 8'h0F; bus.tx_last_i = 1'b1;
    tick();
    chk("tx1_hstb",  {7'd0, bus.host_stb_o}, 8'h01);
    chk("tx1_data",  data_io,                8'h0F);
    chk("tx1_ready", {7'd0, bus.tx_ready_o}, 8'h00);
    bus.tx_valid_i = 1'b0; bus.tx_last_i = 1'b0; bus.tx_data_i = 8'hAA;
    tick();
    chk("turnrx_oe",   {7'd0, bus.oe_o},       8'h00);
    chk("turnrx_hstb", {7'd0, bus.host_stb_o}, 8'h00);
    // Strobe during the turnaround cycle must be ignored
    dev_drive = 1'b1; dev_data = 8'h55; bus.dev_stb_i = 1'b1;
    tick();
    chk("turnrx_ignore_stb", {7'd0, bus.rx_valid_o}, 8'h00);
    chk("turnrx_no_err",     {7'd0, bus.bus_err_o},  8'h00);

    // Response 01, 80(eop)
    dev_data = 8'h01; bus.dev_eop_i = 1'b0;
    tick();
    chk("rx0_valid", {7'd0, bus.rx_valid_o}, 8'h01);
    chk("rx0_data",  bus.rx_data_o,          8'h01);
    chk("rx0_last",  {7'd0, bus.rx_last_o},  8'h00);
    dev_data = 8'h80; bus.dev_eop_i = 1'b1;
    tick();
    chk("rx1_valid", {7'd0, bus.rx_valid_o}, 8'h01);
    chk("rx1_data",  bus.rx_data_o,          8'h80);
    chk("rx1_last",  {7'd0, bus.rx_last_o},  8'h01);
    chk("turntx_busy",  {7'd0, bus.busy_o},     8'h01);
    chk("turntx_ready", {7'd0, bus.tx_ready_o}, 8'h00);
    bus.dev_stb_i = 1'b0; bus.dev_eop_i = 1'b0; dev_drive = 1'b0;
    tick();
    chk("idle_busy",  {7'd0, bus.busy_o},     8'h00);
    chk("idle_ready", {7'd0, bus.tx_ready_o}, 8'h01);
    chk("idle_rxv",   {7'd0, bus.rx_valid_o}, 8'h00);

    // Walking-1 request with gaps; contention strobe in one gap
    for (int i = 0; i < 8; i++) begin
      wb = 8'h01 << i;
      bus.tx_valid_i = 1'b1; bus.tx_data_i = wb; bus.tx_last_i = (i == 7);
      tick();
      chk($sformatf("walk%0d_hstb", i), {7'd0, bus.host_stb_o}, 8'h01);
      chk($sformatf("walk%0d_data", i), data_io,                wb);
      chk($sformatf("walk%0d_err", i),  {7'd0, bus.bus_err_o},  8'h00);
      bus.tx_valid_i = 1'b0; bus.tx_last_i = 1'b0; bus.tx_data_i = 8'hEE;
      if (i < 7) begin
        bus.dev_stb_i = (i == 3);
        tick();
        chk($sformatf("gap%0d_hstb", i), {7'd0, bus.host_stb_o}, 8'h00);
        chk($sformatf("gap%0d_held", i), data_io,                wb);
        chk($sformatf("gap%0d_oe", i),   {7'd0, bus.oe_o},       8'h01);
        chk($sformatf("gap%0d_err", i),  {7'd0, bus.bus_err_o},  (i == 3) ? 8'h01 : 8'h00);
        bus.dev_stb_i = 1'b0;
      end
    end
    tick();
    chk("walk_turn_oe", {7'd0, bus.oe_o}, 8'h00);
    tick(); // now in RX

    saw_valid = 1'b0;
    saw_timeout = 1'b0;
`ifdef HOST_BUS_PORT_TIMEOUT_EN
    // No response: abort after 64 idle RX cycles
    for (int c = 0; c < 63; c++) begin
      tick();
      saw_valid   |= bus.rx_valid_o;
      saw_timeout |= bus.timeout_o;
    end
    chk("to_early_valid",   {7'd0, saw_valid},      8'h00);
    chk("to_early_timeout", {7'd0, saw_timeout},    8'h00);
    tick();
    chk("to_pulse",  {7'd0, bus.timeout_o},  8'h01);
    chk("to_valid",  {7'd0, bus.rx_valid_o}, 8'h01);
    chk("to_last",   {7'd0, bus.rx_last_o},  8'h01);
    chk("to_data",   bus.rx_data_o,          8'h00);
    tick();
    chk("to_pulse_end", {7'd0, bus.timeout_o}, 8'h00);
    chk("to_idle_busy", {7'd0, bus.busy_o},    8'h00);
`else
    // No timeout: RX waits indefinitely, then a late response completes it
    for (int c = 0; c < 80; c++) begin
      tick();
      saw_valid   |= bus.rx_valid_o;
      saw_timeout |= bus.timeout_o;
    end
    chk("wait_no_valid",   {7'd0, saw_valid},   8'h00);
    chk("wait_no_timeout", {7'd0, saw_timeout}, 8'h00);
    chk("wait_busy",       {7'd0, bus.busy_o},  8'h01);
    dev_drive = 1'b1; dev_data = 8'hA5; bus.dev_stb_i = 1'b1; bus.dev_eop_i = 1'b1;
    tick();
    chk("late_data", bus.rx_data_o,         8'hA5);
    chk("late_last", {7'd0, bus.rx_last_o}, 8'h01);
    bus.dev_stb_i = 1'b0; bus.dev_eop_i = 1'b0; dev_drive = 1'b0;
    tick();
    chk("late_idle_busy", {7'd0, bus.busy_o}, 8'h00);
`endif

    // Reset in the middle of TX
    tick();
    bus.tx_valid_i = 1'b1; bus.tx_data_i = 8'h3C; bus.tx_last_i = 1'b0;
    tick();
    chk("midtx_oe", {7'd0, bus.oe_o}, 8'h01);
    bus.tx_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    chk("midrst_oe",   {7'd0, bus.oe_o},       8'h00);
    chk("midrst_busy", {7'd0, bus.busy_o},     8'h00);
    chk("midrst_hstb", {7'd0, bus.host_stb_o}, 8'h00);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("postrst_ready", {7'd0, bus.tx_ready_o}, 8'h01);
    chk("postrst_busy",  {7'd0, bus.busy_o},     8'h00);
    chk("postrst_oe",    {7'd0, bus.oe_o},       8'h00);
    dev_drive = 1'b1; dev_data = 8'h5A;
    #1;
    chk("postrst_released", data_io, 8'h5A);
    dev_drive = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
